// File: rtl/fft_peak_interp_req_pkg.sv
// Shared types and constants for the FFT peak interpolation requester.
package fft_pkg;

    localparam int unsigned FRAC       = 16;
    localparam int unsigned Q_W        = 2 * FRAC;
    localparam int unsigned MAG_W      = 32;
    localparam int unsigned N_BINS_DEF = 1024;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_SCAN = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    typedef logic [MAG_W-1:0] mag_t;

    // Larger of two magnitudes.
    function automatic mag_t mag_max(input mag_t a, input mag_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fft_peak_interp_req_if.sv
// Magnitude stream, divider handshake and result bus of the peak requester.
interface fft_peak_interp_req_if
    import fft_pkg::*;
#(
    parameter int unsigned BIN_W = 10
) ();

    logic             mag_valid;
    mag_t             mag_data;
    logic             mag_last;
    logic             div_start;
    mag_t             div_a;
    mag_t             div_b;
    logic             div_valid_i;
    logic [Q_W-1:0]   div_q;
    logic             res_valid;
    logic [BIN_W-1:0] res_bin;
    logic [Q_W-1:0]   res_frac;
    logic             res_dir;
    logic             res_zero;

    modport slave (
        input  mag_valid, mag_data, mag_last, div_valid_i, div_q,
        output div_start, div_a, div_b, res_valid, res_bin, res_frac, res_dir, res_zero
    );

    modport master (
        output mag_valid, mag_data, mag_last, div_valid_i, div_q,
        input  div_start, div_a, div_b, res_valid, res_bin, res_frac, res_dir, res_zero
    );

endinterface

// File: rtl/fft_peak_interp_req_peak_track.sv
// Peak tracker: running maximum with its left/right neighbours over one frame.
// The _c outputs already include the current sample so the frame end can use them.
module fft_peak_track
    import fft_pkg::*;
#(
    parameter int unsigned BIN_W   = 10,
    parameter int unsigned MIN_BIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smp_en,
    input  logic             clr,
    input  logic [BIN_W-1:0] idx,
    input  mag_t             data,
    output mag_t             pk_c,
    output logic [BIN_W-1:0] pk_bin_c,
    output mag_t             left_c,
    output mag_t             right_c
);

    mag_t             pk_q, left_q, right_q, prev_q, prev_c;
    logic [BIN_W-1:0] pk_bin_q;
    logic             pend_q, pend_c;
    logic             eligible_c;

    assign eligible_c = (idx >= BIN_W'(MIN_BIN));

    // Compare-and-capture; strict compare keeps the first of equal peaks.
    always_comb begin
        pk_c     = pk_q;
        pk_bin_c = pk_bin_q;
        left_c   = left_q;
        right_c  = right_q;
        pend_c   = pend_q;
        prev_c   = prev_q;
        if (smp_en) begin
            if (eligible_c) begin
                if (data > pk_q) begin
                    pk_c     = data;
                    pk_bin_c = idx;
                    left_c   = (idx == '0) ? '0 : prev_q;
                    right_c  = '0;
                    pend_c   = 1'b1;
                end else if (pend_q) begin
                    right_c  = data;
                    pend_c   = 1'b0;
                end
            end
            prev_c = data;
        end
    end

    // Tracker state; cleared when the frame is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_q     <= '0;
            pk_bin_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            prev_q   <= '0;
            pend_q   <= 1'b0;
        end else if (clr) begin
            pk_q     <= '0;
            pk_bin_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            prev_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            pk_q     <= pk_c;
            pk_bin_q <= pk_bin_c;
            left_q   <= left_c;
            right_q  <= right_c;
            prev_q   <= prev_c;
            pend_q   <= pend_c;
        end
    end

endmodule

// File: rtl/fft_peak_interp_req.sv
// Finds the peak bin of each FFT frame and requests nb/(pk+nb) from the shared divider.
// Optional build macro FFT_PEAK_DROP_CNT_EN adds a saturating dropped-frame counter.
module fft_peak_interp_req
    import fft_pkg::*;
#(
    parameter int unsigned N_BINS   = N_BINS_DEF,
    parameter int unsigned BIN_W    = 10,
    parameter int unsigned MIN_BIN  = 1,
    parameter int unsigned DIV_WAIT = 52
) (
    input  logic clk,
    input  logic rst_n,
    fft_peak_interp_req_if.slave bus
`ifdef FFT_PEAK_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned GUARD_W = $clog2(DIV_WAIT + 1);
    localparam int unsigned SUM_W   = MAG_W + 1;

    state_t             state;
    logic [BIN_W-1:0]   bin_cnt;
    logic [GUARD_W-1:0] guard;
    logic [BIN_W-1:0]   bin_cap;
    logic               dir_cap;

    logic               frame_end_c, in_scan_c, scan_end_c, dir_c;
    mag_t               pk_c, left_c, right_c, nb_c;
    logic [BIN_W-1:0]   pk_bin_c;
    logic [SUM_W-1:0]   sum_c;

    assign frame_end_c = bus.mag_valid && bus.mag_last;
    assign in_scan_c   = (state == ST_SCAN);
    assign scan_end_c  = frame_end_c && in_scan_c;
    assign nb_c        = mag_max(left_c, right_c);
    assign dir_c       = (right_c > left_c);
    assign sum_c       = SUM_W'(pk_c) + SUM_W'(nb_c);

    fft_peak_track #(
        .BIN_W   (BIN_W),
        .MIN_BIN (MIN_BIN)
    ) u_track (
        .clk      (clk),
        .rst_n    (rst_n),
        .smp_en   (bus.mag_valid && in_scan_c),
        .clr      (scan_end_c),
        .idx      (bin_cnt),
        .data     (bus.mag_data),
        .pk_c     (pk_c),
        .pk_bin_c (pk_bin_c),
        .left_c   (left_c),
        .right_c  (right_c)
    );

    // Bin index of the incoming sample; runs in every state to keep frame alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
        end else if (bus.mag_valid) begin
            if (bus.mag_last || bin_cnt == BIN_W'(N_BINS - 1)) begin
                bin_cnt <= '0;
            end else begin
                bin_cnt <= bin_cnt + BIN_W'(1);
            end
        end
    end

    // Frame sequencing and divider handshake; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_SYNC;
            guard         <= '0;
            bin_cap       <= '0;
            dir_cap       <= 1'b0;
            bus.div_start <= 1'b0;
            bus.div_a     <= '0;
            bus.div_b     <= '0;
            bus.res_valid <= 1'b0;
            bus.res_bin   <= '0;
            bus.res_frac  <= '0;
            bus.res_dir   <= 1'b0;
            bus.res_zero  <= 1'b0;
        end else begin
            bus.div_start <= 1'b0;
            bus.res_valid <= 1'b0;
            unique case (state)
                ST_SYNC: begin
                    if (frame_end_c) state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (frame_end_c) begin
                        if (pk_c == '0) begin
                            bus.res_valid <= 1'b1;
                            bus.res_bin   <= pk_bin_c;
                            bus.res_frac  <= '0;
                            bus.res_dir   <= 1'b0;
                            bus.res_zero  <= 1'b1;
                            state         <= ST_OUT;
                        end else begin
                            bus.div_start <= 1'b1;
                            bus.div_a     <= nb_c >> 1;
                            bus.div_b     <= sum_c[SUM_W-1:1];
                            bin_cap       <= pk_bin_c;
                            dir_cap       <= dir_c;
                            state         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    guard <= GUARD_W'(DIV_WAIT);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (guard != '0) begin
                        guard <= guard - GUARD_W'(1);
                    end else if (bus.div_valid_i) begin
                        bus.res_valid <= 1'b1;
                        bus.res_bin   <= bin_cap;
                        bus.res_frac  <= bus.div_q;
                        bus.res_dir   <= dir_cap;
                        bus.res_zero  <= 1'b0;
                        bus.div_a     <= '0;
                        bus.div_b     <= '0;
                        state         <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    state <= (bin_cnt == '0) ? ST_SCAN : ST_SYNC;
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

`ifdef FFT_PEAK_DROP_CNT_EN
    logic sync_seen;

    // Counts frames ending outside SCAN, skipping the initial alignment frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            sync_seen <= 1'b0;
        end else if (frame_end_c && !in_scan_c) begin
            if (state == ST_SYNC && !sync_seen) begin
                sync_seen <= 1'b1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fft_peak_interp_req.md
Name: fft_peak_interp_req

Overview:
- Sits between the FFT magnitude stream and the shared Q16.16 unsigned divider.
- Scans one frame of bin magnitudes and finds the peak bin, excluding bins below MIN_BIN.
- Captures the larger neighbour of the peak and requests fraction = nb/(pk+nb) from the divider.
- Returns peak bin, Q16.16 fractional offset and direction as one result pulse per frame, for sub-bin frequency estimation on the oscilloscope display.

Parameters:
- N_BINS, 1024: bins per frame. Must be a power of two.
- BIN_W, 10: bin index width, log2(N_BINS).
- MIN_BIN, 1: first bin eligible as peak. Default excludes DC.
- DIV_WAIT, 52: cycles after div_start before div_valid_i is trusted. Must be ≥ 50.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mag_valid  in  1  magnitude sample valid
- mag_data  in  32  unsigned magnitude
- mag_last  in  1  last bin of frame, qualified by mag_valid
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  32  dividend
- div_b  out  32  divisor
- div_valid_i  in  1  divider result valid (also high while divider idle)
- div_q  in  32  divider Q16.16 quotient
- res_valid  out  1  one-cycle result strobe
- res_bin  out  BIN_W  peak bin index
- res_frac  out  32  Q16.16 offset, range [0, 0.5]
- res_dir  out  1  1 = offset toward bin+1, 0 = toward bin-1
- res_zero  out  1  peak magnitude was 0; res_frac forced to 0

Behaviour:
- Reset: all outputs 0; state SYNC; bin counter 0.
- Bin counter increments on each mag_valid and clears on mag_valid&&mag_last. No backpressure exists; samples outside SCAN are discarded.
- SYNC: wait for mag_valid&&mag_last, then go to SCAN. Frame alignment is guaranteed from the next sample.
- SCAN, per sample at index i ≥ MIN_BIN:
  - If mag_data > pk (strict, so ties keep the first bin): pk←mag_data, pk_bin←i, left←prev sample (0 if i==0), right←0, arm right_pending.
  - Else if right_pending: right←mag_data, clear right_pending.
  - prev register always updates with mag_data.
- Frame end (mag_valid&&mag_last in SCAN):
  - The final sample is evaluated first, in the same cycle.
  - A peak on the last bin keeps right=0.
  - Computed pk==0 → OUT with res_zero=1. Otherwise → REQ.
  - pk/left/right/prev/right_pending clear on the transition.
- REQ (1 cycle):
  - nb = max(left,right); res_dir = right>left (tie → 0).
  - div_a = nb>>1; div_b = 33-bit (pk+nb)>>1.
  - div_start=1 for exactly this cycle; guard counter←DIV_WAIT.
  - div_a/div_b hold until leaving WAIT.
- WAIT:
  - Guard decrements each cycle. div_valid_i is ignored while guard≠0.
  - The first cycle with guard==0 && div_valid_i captures div_q into res_frac → OUT.
- OUT:
  - res_valid=1 for one cycle.
  - res_bin/res_frac/res_dir/res_zero hold until the next OUT.
  - Next state is SCAN if the bin counter is 0 (frame-aligned), else SYNC.
- Frames arriving during REQ/WAIT/OUT are dropped whole. Latency from mag_last to res_valid is DIV_WAIT+3 cycles nominal.
- rst_n asserted mid-operation: immediate return to reset state. No res_valid is issued for the aborted frame.

Optional Feature:
- Macro FFT_PEAK_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [15:0], reset 0.
  - drop_cnt increments, saturating at 16'hFFFF, on every mag_valid&&mag_last seen outside SCAN, except the first in SYNC after reset.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package fft_pkg: state encoding (SYNC, SCAN, REQ, WAIT, OUT), Q16.16 FRAC=16 constant, MAG_W=32, default N_BINS.
- Sub-module fft_peak_track: combinational/registered compare-and-capture of pk, pk_bin, left, right, prev. The FSM and divider handshake stay in the top module.

Test Plan:
- Reset, one sync frame, then frame with bin 100=1000, 99=200, 101=600, others 10 → div_a=300, div_b=800, div_start once; with div_q=0x00006000 → res_bin=100, res_frac=0x00006000, res_dir=1, res_zero=0.
- All-zero frame → res_valid with res_zero=1, res_frac=0, no div_start.
- DC bin 0=50000, bin 5=40, bins 4 and 6 = 0 → res_bin=5 (DC excluded), div_a=0, div_b=20, res_dir=0.
- Peak at last bin 1023=0xFFFFFFFF, bin 1022=0xFFFFFFFF, tie elsewhere absent → res_bin=1022 (first-occurrence tie rule), nb=0xFFFFFFFF, div_b=0xFFFFFFFF with no overflow.
- Hold div_valid_i=1 constantly during WAIT → capture occurs exactly DIV_WAIT cycles after div_start; frame sent during WAIT produces no result (drop_cnt=1 with FFT_PEAK_DROP_CNT_EN).
- Assert rst_n low during WAIT → all outputs 0 next cycle; no res_valid; block resyncs on next mag_last.
